// File: rtl/morse_pkg.sv
// Shared definitions for the Morse entry path: FSM state encoding and the
// symbol codes the downstream value-builder concatenates per dot / line.
package morse_pkg;

    // Decoder FSM state encoding (ABORT_WAIT only reachable with MORSE_ABORT_EN)
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PRESS      = 2'd1;
    localparam logic [1:0] GAP        = 2'd2;
    localparam logic [1:0] ABORT_WAIT = 2'd3;

    // Symbol codes appended by the value-builder
    localparam logic [1:0] DOT_CODE  = 2'b10;
    localparam logic [3:0] LINE_CODE = 4'b1110;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus counting debouncer for the raw Morse key.
// key_level changes only after the synchronised input has disagreed with it
// for DEBOUNCE_CYC consecutive cycles; rise/fall are one-cycle edge pulses
// derived from a registered copy of key_level.
module key_debouncer
    import morse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic clock,
    input  logic resetn,
    input  logic input_in,
    output logic key_level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 32'd1);

    logic             sync1_r;
    logic             sync_in_r;
    logic             key_level_r;
    logic             key_level_d_r;
    logic [CNT_W-1:0] db_cnt_r;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_r   <= 1'b0;
            sync_in_r <= 1'b0;
        end else begin
            sync1_r   <= input_in;
            sync_in_r <= sync1_r;
        end
    end

    // Count consecutive disagreement; toggle the level once it has lasted long enough
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_level_r <= 1'b0;
            db_cnt_r    <= CNT_ZERO;
        end else if (sync_in_r == key_level_r) begin
            db_cnt_r    <= CNT_ZERO;
        end else if (db_cnt_r == DB_LAST) begin
            key_level_r <= ~key_level_r;
            db_cnt_r    <= CNT_ZERO;
        end else begin
            db_cnt_r    <= db_cnt_r + CNT_ONE;
        end
    end

    // Delayed copy of the debounced level for edge detection
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_level_d_r <= 1'b0;
        end else begin
            key_level_d_r <= key_level_r;
        end
    end

    assign key_level = key_level_r;
    assign rise      = key_level_r & ~key_level_d_r;
    assign fall      = ~key_level_r & key_level_d_r;

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key decoder: debounced button -> one-cycle ld_dot / ld_line / ld_gap
// strobes. Press length picks dot vs line; a long silence after a symbol
// ends the letter. Optional macro MORSE_ABORT_EN adds a press-abort path
// (ld_abort + ABORT_WAIT state); without it ld_abort is tied to 0.
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned LINE_MIN_CYC = 12500000,
    parameter int unsigned GAP_CYC      = 37500000,
    parameter int unsigned ABORT_CYC    = 75000000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic clock,
    input  logic resetn,
    input  logic input_in,
    output logic ld_dot,
    output logic ld_line,
    output logic ld_gap,
    output logic ld_abort,
    output logic key_level,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LINE_MIN = CNT_W'(LINE_MIN_CYC);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 32'd1);
`ifdef MORSE_ABORT_EN
    localparam logic [CNT_W-1:0] ABORT_LIM = CNT_W'(ABORT_CYC);
`endif

    // Press counter holds at all-ones so a very long press still reads as a line
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic             rise_s;
    logic             fall_s;
    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CNT_W-1:0] press_cnt_r;
    logic [CNT_W-1:0] press_cnt_s;
    logic [CNT_W-1:0] gap_cnt_r;
    logic [CNT_W-1:0] gap_cnt_s;
    logic             dot_s;
    logic             line_s;
    logic             gap_s;
    logic             ld_dot_r;
    logic             ld_line_r;
    logic             ld_gap_r;
    logic             busy_r;
`ifdef MORSE_ABORT_EN
    logic             abort_s;
    logic             ld_abort_r;
`endif

    key_debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_debouncer (
        .clock     (clock),
        .resetn    (resetn),
        .input_in  (input_in),
        .key_level (key_level),
        .rise      (rise_s),
        .fall      (fall_s)
    );

    // Next-state, counter and strobe decode for the press/gap timer FSM
    always_comb begin
        state_s     = state_r;
        press_cnt_s = press_cnt_r;
        gap_cnt_s   = gap_cnt_r;
        dot_s       = 1'b0;
        line_s      = 1'b0;
        gap_s       = 1'b0;
`ifdef MORSE_ABORT_EN
        abort_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_s     = PRESS;
                    press_cnt_s = CNT_ONE;
                end else begin
                    state_s     = IDLE;
                end
            end
            PRESS: begin
                if (fall_s) begin
                    if (press_cnt_r < LINE_MIN) begin
                        dot_s  = 1'b1;
                    end else begin
                        line_s = 1'b1;
                    end
                    state_s   = GAP;
                    gap_cnt_s = CNT_ZERO;
`ifdef MORSE_ABORT_EN
                end else if (press_cnt_r == ABORT_LIM) begin
                    abort_s = 1'b1;
                    state_s = ABORT_WAIT;
`endif
                end else begin
                    press_cnt_s = sat_inc(press_cnt_r);
                end
            end
            GAP: begin
                // A new press beats the terminal count, so no ld_gap then
                if (rise_s) begin
                    state_s     = PRESS;
                    press_cnt_s = CNT_ONE;
                end else if (gap_cnt_r == GAP_LAST) begin
                    gap_s     = 1'b1;
                    state_s   = IDLE;
                    gap_cnt_s = CNT_ZERO;
                end else begin
                    gap_cnt_s = gap_cnt_r + CNT_ONE;
                end
            end
`ifdef MORSE_ABORT_EN
            ABORT_WAIT: begin
                if (fall_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ABORT_WAIT;
                end
            end
`endif
            default: begin
                state_s     = IDLE;
                press_cnt_s = CNT_ZERO;
                gap_cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state and timing counters
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            press_cnt_r <= CNT_ZERO;
            gap_cnt_r   <= CNT_ZERO;
        end else begin
            state_r     <= state_s;
            press_cnt_r <= press_cnt_s;
            gap_cnt_r   <= gap_cnt_s;
        end
    end

    // Registered strobes and busy flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ld_dot_r  <= 1'b0;
            ld_line_r <= 1'b0;
            ld_gap_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            ld_dot_r  <= dot_s;
            ld_line_r <= line_s;
            ld_gap_r  <= gap_s;
            busy_r    <= (state_s != IDLE);
        end
    end

`ifdef MORSE_ABORT_EN
    // Registered abort strobe
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ld_abort_r <= 1'b0;
        end else begin
            ld_abort_r <= abort_s;
        end
    end

    assign ld_abort = ld_abort_r;
`else
    assign ld_abort = 1'b0;
`endif

    assign ld_dot  = ld_dot_r;
    assign ld_line = ld_line_r;
    assign ld_gap  = ld_gap_r;
    assign busy    = busy_r;

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
Upstream stage of the player entry path. It turns one raw push-button line into one-cycle symbol strobes: ld_dot, ld_line and an end-of-letter ld_gap. The player value-builder consumes these strobes and concatenates 2'b10 per dot and 4'b1110 per line. The block synchronises and debounces the button, times each press and times the silence after each release.

Parameters:
- DEBOUNCE_CYC, 500000: cycles the synchronised input must stay stable before the debounced level changes (10 ms at 50 MHz).
- LINE_MIN_CYC, 12500000: a press of this many debounced cycles or more is a line; anything shorter is a dot.
- GAP_CYC, 37500000: idle cycles after a release that end a letter.
- ABORT_CYC, 75000000: press length that cancels the symbol (used only with the optional feature).
- CNT_W, 27: width of the timing counters. Must be able to hold the largest of the cycle parameters.

Ports:
- clock, input, 1: system clock.
- resetn, input, 1: asynchronous active-low reset.
- input_in, input, 1: raw button, active-high, asynchronous to clock.
- ld_dot, output, 1: one-cycle strobe, dot completed.
- ld_line, output, 1: one-cycle strobe, line completed.
- ld_gap, output, 1: one-cycle strobe, letter ended.
- ld_abort, output, 1: one-cycle strobe, press cancelled (tied to 0 without the optional feature).
- key_level, output, 1: debounced button level.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset:
  - Asynchronous, applies at any time.
  - All outputs go to 0, the FSM goes to IDLE, all counters go to 0, sync flops go to 0.
  - Reset mid-press drops the symbol; no strobe is produced.
- Synchroniser: two flops on input_in, giving sync_in.
- Debouncer:
  - The counter clears whenever sync_in equals key_level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYC-1, key_level toggles and the counter clears.
  - Edge-to-key_level latency is exactly 2 + DEBOUNCE_CYC cycles for a clean edge.
  - Any glitch shorter than DEBOUNCE_CYC is ignored.
- rise and fall are single-cycle pulses derived from a registered copy of key_level.
- FSM states: IDLE, PRESS, GAP.
  - IDLE: on rise, go to PRESS with press_cnt=1.
  - PRESS: press_cnt increments and saturates at all-ones. On fall, classify (rule below) and go to GAP with gap_cnt=0.
  - Classification on fall: press_cnt < LINE_MIN_CYC gives ld_dot, otherwise ld_line.
  - GAP: gap_cnt increments. On rise, go to PRESS with press_cnt=1 and no ld_gap. When gap_cnt reaches GAP_CYC-1, pulse ld_gap and go to IDLE.
- All strobes are registered and asserted in the cycle after the triggering fall or terminal count.
- At most one strobe is high in any cycle.
- A rise in the same cycle as the GAP terminal count: rise wins, so no ld_gap is produced.
- ld_gap is produced only after at least one symbol. IDLE never emits ld_gap.
- busy equals (state != IDLE).

Optional Feature:
- Macro: MORSE_ABORT_EN.
- Defined: while in PRESS, if press_cnt reaches ABORT_CYC, pulse ld_abort once and go to an extra state ABORT_WAIT. ABORT_WAIT holds until fall, then returns to IDLE with no ld_dot, ld_line or ld_gap. A downstream stage may use ld_abort to clear the entered value.
- Undefined: the ABORT_WAIT state and its logic are not compiled. ld_abort is a constant 0. Long presses classify as lines.

Decomposition:
- Shared package morse_pkg holds:
  - the state encoding: IDLE=2'd0, PRESS=2'd1, GAP=2'd2, ABORT_WAIT=2'd3;
  - the symbol codes DOT_CODE=2'b10 and LINE_CODE=4'b1110, also used by the value-builder.
- One natural sub-module, key_debouncer: the synchroniser plus debouncer, producing key_level, rise and fall.
- The FSM and timers stay in the top.

Test Plan (simulation parameters DEBOUNCE_CYC=4, LINE_MIN_CYC=20, GAP_CYC=40, ABORT_CYC=60, CNT_W=8):
- Hold input_in high for 10 cycles, then release → exactly one ld_dot, 1 cycle after key_level falls; ld_gap 40 cycles later; busy returns to 0.
- Hold high for 30 cycles → exactly one ld_line; no ld_dot.
- 2-cycle glitch high while idle → key_level stays 0, no strobes, busy stays 0.
- Dot, 15 idle cycles, line, then idle → sequence ld_dot, ld_line, ld_gap; exactly one ld_gap, issued after the line.
- Assert resetn=0 mid-press (cycle 12 of 30) → all outputs 0 immediately; no strobes after reset is released while the button stays low.
- With MORSE_ABORT_EN, hold high for 80 cycles → ld_abort once at press_cnt=60; no ld_line or ld_gap after release.
- Without MORSE_ABORT_EN, hold high for 80 cycles → ld_line once.
